// File: rtl/instr_encoder.sv
// instr_encoder: turns abstract operations for the 9-bit accumulator ISA into
// their 1- or 2-word machine encodings and streams them into instruction RAM
// at a self-incrementing address. Illegal requests are dropped with a one-cycle
// err pulse. A request that would not fit is refused whole and the encoder
// halts with overflow set. The DONE terminator sets done and halts.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready for a request (unless Start is asserted this cycle)
// S_ARG  | opcode word written, argument word goes out on the next edge
// S_HALT | DONE written or overflow refused; waits for Start
module instr_encoder #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_class,
    input  logic [3:0]        i_req_op,
    input  logic [1:0]        i_req_mode,
    input  logic              i_req_flag,
    input  logic [8:0]        i_req_operand,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [8:0]        o_wr_data,
    output logic              o_done,
    output logic              o_overflow,
    output logic              o_err
);

    // Two spare bits so that count + 2 can never wrap before the DEPTH compare.
    localparam int               CNT_W   = ADDR_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] CLS_MISC   = 2'd0;
    localparam logic [1:0] CLS_MATH   = 2'd1;
    localparam logic [1:0] CLS_BRANCH = 2'd2;

    localparam logic [1:0] MODE_MEM  = 2'b00;
    localparam logic [1:0] MODE_TGT  = 2'b01;
    localparam logic [1:0] MODE_IMM  = 2'b10;
    localparam logic [1:0] MODE_LFSR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARG  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [8:0]         r_arg;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [8:0]         r_wr_data;
    logic               r_done;
    logic               r_overflow;
    logic               r_err;

    logic               w_legal;
    logic               w_two;
    logic               w_is_done;
    logic [8:0]         w_op_word;
    logic [8:0]         w_arg_word;
    logic               w_tgt_ok;
    logic               w_imm_ok;
    logic               w_math_no_tgt;
    logic [CNT_W-1:0]   w_words;
    logic               w_fits;

    // Ready is combinational so that Start blocks a request in the same cycle.
    assign o_req_ready = i_rst_n & (r_state == S_IDLE) & ~i_start;

    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_err      = r_err;

    // Request decode: legality, word count and both encoded words.
    always_comb begin
        w_legal       = 1'b0;
        w_two         = 1'b0;
        w_is_done     = 1'b0;
        w_op_word     = '0;
        w_arg_word    = '0;
        w_tgt_ok      = ~i_req_operand[8];
        w_imm_ok      = (i_req_operand[8:7] == 2'b00);
        w_math_no_tgt = (i_req_op == 4'b0100) || (i_req_op == 4'b1001);

        case (i_req_class)
            CLS_MISC: begin
                w_op_word = {5'b0_0000, i_req_op};
                case (i_req_op)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011,
                    4'b0100, 4'b0101, 4'b1000, 4'b1110: begin
                        w_legal = 1'b1;
                    end
                    4'b1111: begin
                        w_legal   = 1'b1;
                        w_is_done = 1'b1;
                    end
                    4'b1100, 4'b1101: begin
                        w_legal    = w_tgt_ok;
                        w_two      = 1'b1;
                        w_arg_word = i_req_operand;
                    end
                    default: begin
                        w_legal = 1'b0;
                    end
                endcase
            end
            CLS_MATH: begin
                w_op_word = {1'b0, i_req_op, i_req_mode, i_req_flag, 1'b0};
                if ((i_req_op != 4'b0000) && (i_req_op <= 4'b1001)) begin
                    case (i_req_mode)
                        MODE_MEM: begin
                            w_legal = 1'b1;
                        end
                        MODE_TGT: begin
                            w_legal    = w_tgt_ok & ~w_math_no_tgt;
                            w_two      = 1'b1;
                            w_arg_word = i_req_operand;
                        end
                        MODE_IMM: begin
                            w_legal    = w_imm_ok;
                            w_two      = 1'b1;
                            w_arg_word = {2'b00, i_req_operand[6:0]};
                        end
                        MODE_LFSR: begin
                            w_legal = ~w_math_no_tgt;
                        end
                        default: begin
                            w_legal = 1'b0;
                        end
                    endcase
                end
            end
            CLS_BRANCH: begin
                w_op_word  = {1'b1, i_req_op, 4'b0000};
                w_arg_word = i_req_operand;
                w_two      = 1'b1;
                w_legal    = (i_req_op >= 4'b1000) && (i_req_op <= 4'b1110);
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Refuse the whole request if all of its words would not fit below DEPTH.
    assign w_words = w_two ? CNT_W'(2) : CNT_W'(1);
    assign w_fits  = (r_cnt + w_words) <= DEPTH_C;

    // Sequencer: accepts requests, emits registered write strobes, tracks flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_arg      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
            if (i_start) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_req_valid) begin
                            if (!w_legal) begin
                                r_err <= 1'b1;
                            end else if (!w_fits) begin
                                r_overflow <= 1'b1;
                                r_state    <= S_HALT;
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_cnt[ADDR_W-1:0];
                                r_wr_data <= w_op_word;
                                r_cnt     <= r_cnt + CNT_W'(1);
                                if (w_is_done) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_HALT;
                                end else if (w_two) begin
                                    r_arg   <= w_arg_word;
                                    r_state <= S_ARG;
                                end
                            end
                        end
                    end
                    S_ARG: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt[ADDR_W-1:0];
                        r_wr_data <= r_arg;
                        r_cnt     <= r_cnt + CNT_W'(1);
                        r_state   <= S_IDLE;
                    end
                    S_HALT: begin
                        r_state <= S_HALT;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized requests, all
// checked against a transaction-level model of the encoding rules.
module tb_instr_encoder;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 20;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic              i_req_valid;
    logic              o_req_ready;
    logic [1:0]        i_req_class;
    logic [3:0]        i_req_op;
    logic [1:0]        i_req_mode;
    logic              i_req_flag;
    logic [8:0]        i_req_operand;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [8:0]        o_wr_data;
    logic              o_done;
    logic              o_overflow;
    logic              o_err;

    int n_vec  = 0;
    int n_miss = 0;

    // model state
    int m_addr = 0;
    bit m_done = 0;
    bit m_ovf  = 0;
    bit m_halt = 0;

    logic [8:0] d0, d1;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_class   (i_req_class),
        .i_req_op      (i_req_op),
        .i_req_mode    (i_req_mode),
        .i_req_flag    (i_req_flag),
        .i_req_operand (i_req_operand),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_done        (o_done),
        .o_overflow    (o_overflow),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Encoding rules expressed arithmetically on field values.
    function automatic void model_encode(input int cls, input int op, input int mode,
                                         input int flag, input int operand,
                                         output bit ok, output int n, output bit is_done,
                                         output int w0, output int w1);
        bit no_tgt;
        ok = 0; n = 0; is_done = 0; w0 = 0; w1 = 0;
        no_tgt = (op == 4) || (op == 9);
        if (cls == 0) begin
            w0 = op;
            if (op <= 5 || op == 8 || op == 14) begin
                ok = 1; n = 1;
            end else if (op == 15) begin
                ok = 1; n = 1; is_done = 1;
            end else if (op == 12 || op == 13) begin
                ok = (operand < 256); n = 2; w1 = operand;
            end
        end else if (cls == 1) begin
            w0 = op * 16 + mode * 4 + flag * 2;
            if (op >= 1 && op <= 9) begin
                if (mode == 0) begin
                    ok = 1; n = 1;
                end else if (mode == 1) begin
                    ok = !no_tgt && operand < 256; n = 2; w1 = operand;
                end else if (mode == 2) begin
                    ok = operand < 128; n = 2; w1 = operand % 128;
                end else begin
                    ok = !no_tgt; n = 1;
                end
            end
        end else if (cls == 2) begin
            w0 = 256 + op * 16;
            w1 = operand;
            n  = 2;
            ok = (op >= 8 && op <= 14);
        end
    endfunction

    task automatic m_clear();
        m_addr = 0; m_done = 0; m_ovf = 0; m_halt = 0;
    endtask

    // Called at a negedge; applies one request and checks its full outcome.
    task automatic do_req(input int cls, input int op, input int mode, input int flag,
                          input int operand, output logic [8:0] o_d0, output logic [8:0] o_d1);
        bit ok, is_done;
        int n, w0, w1;
        model_encode(cls, op, mode, flag, operand, ok, n, is_done, w0, w1);
        o_d0 = '0; o_d1 = '0;
        i_req_class   = 2'(cls);
        i_req_op      = 4'(op);
        i_req_mode    = 2'(mode);
        i_req_flag    = 1'(flag);
        i_req_operand = 9'(operand);
        i_req_valid   = 1'b1;
        #1;
        chk("ready_before", 32'(o_req_ready), 32'(!m_halt));
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        if (m_halt) begin
            chk("halt_no_write", 32'(o_wr_en), 0);
        end else if (!ok) begin
            chk("illegal_err", 32'(o_err), 1);
            chk("illegal_no_write", 32'(o_wr_en), 0);
            @(negedge clk);
            chk("err_one_cycle", 32'(o_err), 0);
            chk("illegal_no_write2", 32'(o_wr_en), 0);
        end else if (m_addr + n > DEPTH) begin
            chk("ovf_no_write", 32'(o_wr_en), 0);
            chk("ovf_err_low", 32'(o_err), 0);
            m_ovf  = 1;
            m_halt = 1;
        end else begin
            chk("op_wr_en", 32'(o_wr_en), 1);
            chk("op_addr", 32'(o_wr_addr), m_addr);
            chk("op_data", 32'(o_wr_data), w0);
            chk("op_err_low", 32'(o_err), 0);
            o_d0 = o_wr_data;
            m_addr++;
            if (is_done) begin
                m_done = 1;
                m_halt = 1;
            end
            if (n == 2) begin
                #1;
                chk("arg_ready_low", 32'(o_req_ready), 0);
                @(negedge clk);
                chk("arg_wr_en", 32'(o_wr_en), 1);
                chk("arg_addr", 32'(o_wr_addr), m_addr);
                chk("arg_data", 32'(o_wr_data), w1);
                o_d1 = o_wr_data;
                m_addr++;
            end
        end
        chk("done", 32'(o_done), 32'(m_done));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        #1;
        chk("ready_after", 32'(o_req_ready), 32'(!m_halt));
    endtask

    // Called at a negedge; pulses Start, optionally with a competing request.
    task automatic do_start(input bit with_req);
        i_start       = 1'b1;
        i_req_class   = 2'd1;
        i_req_op      = 4'd1;
        i_req_mode    = 2'd0;
        i_req_flag    = 1'b0;
        i_req_operand = '0;
        i_req_valid   = with_req;
        #1;
        chk("start_ready_low", 32'(o_req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        i_start     = 1'b0;
        i_req_valid = 1'b0;
        chk("start_no_write", 32'(o_wr_en), 0);
        chk("start_done_clr", 32'(o_done), 0);
        chk("start_ovf_clr", 32'(o_overflow), 0);
        m_clear();
        #1;
        chk("start_ready", 32'(o_req_ready), 1);
    endtask

    initial begin
        int op, mode, operand, cls;
        rst_n         = 1'b1;
        i_start       = 1'b0;
        i_req_valid   = 1'b1;
        i_req_class   = '0;
        i_req_op      = '0;
        i_req_mode    = '0;
        i_req_flag    = 1'b0;
        i_req_operand = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(o_req_ready), 0);
        chk("rst_wr_en", 32'(o_wr_en), 0);
        chk("rst_wr_addr", 32'(o_wr_addr), 0);
        chk("rst_wr_data", 32'(o_wr_data), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_ovf", 32'(o_overflow), 0);
        chk("rst_err", 32'(o_err), 0);
        @(negedge clk);
        i_req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        m_clear();

        // Start beats a simultaneous valid request
        do_start(1'b1);

        do_req(1, 1, 0, 0, 9'h000, d0, d1);
        chk("tp_add_mem", 32'(d0), 32'h010);
        do_req(1, 1, 2, 0, 9'h005, d0, d1);
        chk("tp_add_imm_w0", 32'(d0), 32'h018);
        chk("tp_add_imm_w1", 32'(d1), 32'h005);
        do_req(2, 14, 0, 0, 9'h123, d0, d1);
        chk("tp_beq_w0", 32'(d0), 32'h1E0);
        chk("tp_beq_w1", 32'(d1), 32'h123);
        do_req(1, 10, 0, 0, 9'h000, d0, d1);
        do_req(1, 3, 3, 1, 9'h000, d0, d1);
        chk("tp_after_err_addr", 32'(o_wr_addr), 5);

        // back-to-back single-word throughput
        for (int k = 0; k < 3; k++) begin
            bit ok, isd;
            int n, w0, w1;
            model_encode(1, k + 1, 0, k % 2, 0, ok, n, isd, w0, w1);
            i_req_class = 2'd1;
            i_req_op    = 4'(k + 1);
            i_req_mode  = 2'd0;
            i_req_flag  = 1'(k % 2);
            i_req_valid = 1'b1;
            #1;
            chk("burst_ready", 32'(o_req_ready), 1);
            @(posedge clk);
            @(negedge clk);
            chk("burst_wr_en", 32'(o_wr_en), 1);
            chk("burst_addr", 32'(o_wr_addr), m_addr);
            chk("burst_data", 32'(o_wr_data), w0);
            m_addr++;
        end
        i_req_valid = 1'b0;

        // DONE terminator, refused request while halted, Start restarts at 0
        do_req(0, 15, 0, 0, 0, d0, d1);
        chk("tp_done_word", 32'(d0), 32'h00F);
        do_req(1, 1, 0, 0, 0, d0, d1);
        do_start(1'b0);
        do_req(1, 2, 0, 1, 0, d0, d1);
        chk("restart_addr", 32'(o_wr_addr), 0);

        // Start during ARG drops the argument word
        i_req_class = 2'd2; i_req_op = 4'd8; i_req_operand = 9'h0AA; i_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("sarg_w0", 32'(o_wr_data), 32'h180);
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        chk("sarg_abandon", 32'(o_wr_en), 0);
        m_clear();
        do_req(1, 5, 1, 0, 9'h033, d0, d1);

        // Reset during ARG drops the argument word
        i_req_class = 2'd0; i_req_op = 4'd13; i_req_operand = 9'h044; i_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("rarg_w0", 32'(o_wr_data), 32'h00D);
        rst_n = 1'b0;
        #1;
        chk("rarg_wr_en", 32'(o_wr_en), 0);
        chk("rarg_ready", 32'(o_req_ready), 0);
        chk("rarg_addr", 32'(o_wr_addr), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rarg_no_arg", 32'(o_wr_en), 0);
        rst_n = 1'b1;
        m_clear();
        @(negedge clk);

        // exact fill: 18 singles + one pair reaches DEPTH, next single overflows
        do_start(1'b0);
        for (int k = 0; k < DEPTH - 2; k++) do_req(1, 1, 0, 0, 0, d0, d1);
        do_req(0, 13, 0, 0, 9'h055, d0, d1);
        chk("fill_last_addr", 32'(o_wr_addr), DEPTH - 1);
        do_req(0, 0, 0, 0, 0, d0, d1);
        chk("fill_ovf", 32'(o_overflow), 1);

        // one slot left: a pair is refused whole
        do_start(1'b0);
        for (int k = 0; k < DEPTH - 1; k++) do_req(1, 7, 0, 1, 0, d0, d1);
        do_req(0, 12, 0, 0, 9'h010, d0, d1);
        chk("pair_ovf", 32'(o_overflow), 1);
        do_start(1'b0);

        // randomized requests
        for (int it = 0; it < 400; it++) begin
            if (m_halt || $urandom_range(0, 24) == 0) begin
                do_start(1'($urandom_range(0, 1)));
            end else begin
                cls     = $urandom_range(0, 3);
                op      = $urandom_range(0, 15);
                mode    = $urandom_range(0, 3);
                operand = $urandom_range(0, 511);
                if ($urandom_range(0, 1) == 1) operand = operand % 128;
                do_req(cls, op, mode, $urandom_range(0, 1), operand, d0, d1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Hardware encoder for the 9-bit accumulator ISA and the write-side counterpart of the control decoder. Accepts one abstract operation per valid/ready handshake and emits its 1- or 2-word machine encoding (opcode word, then target/immediate word) into instruction memory at a self-incrementing address. Used by the test harness and boot loader to build programs in instruction RAM. Flags illegal requests, memory overflow and the DONE terminator.

Parameters:
ADDR_W, 9, instruction memory address width
DEPTH, 512, number of writable instruction words (DEPTH <= 2**ADDR_W)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  pulse: address to 0, clear done/overflow, go IDLE
req_valid  in  1  request present
req_ready  out  1  encoder can accept this cycle
req_class  in  2  0=misc, 1=math, 2=branch, 3=illegal
req_op  in  4  operation code, placed in word[7:4] (misc: in word[3:0])
req_mode  in  2  math argument mode: 00 mem, 01 target, 10 immediate, 11 LFSR
req_flag  in  1  math shift kind: 1=arith, 0=zero-fill, placed in word[1]
req_operand  in  9  target address / immediate / branch target
wr_en  out  1  instruction memory write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  9  instruction word
done  out  1  sticky: DONE word written
overflow  out  1  sticky: request refused, would exceed DEPTH
err  out  1  one-cycle pulse: illegal request dropped

Behaviour:
- Reset (Reset=0, async): state IDLE, addr counter 0, wr_en=0, wr_addr=0, wr_data=0, done=0, overflow=0, err=0; req_ready=0 while Reset is low.
- States: IDLE, ARG, HALT. req_ready=1 only in IDLE with Start=0.
- Word formats: branch = {1, op, 0000}, op in 1000..1110, second word = req_operand (all 9 bits). Misc = {0, 0000, op}; legal ops 0000-0101, 1000, 1100, 1101, 1110, 1111; 1100/1101 take second word = req_operand. Math = {0, op, mode, flag, 0}, op in 0001..1001; mode 01 second word = req_operand; mode 10 second word = {00, req_operand[6:0]}.
- Illegal (err pulse next cycle, no write, counter unchanged, stay IDLE): class 3; branch op outside 1000..1110; misc op 0110, 0111, 1001-1011; math op 0000 or >1001; math mode 01 or 11 with op 0100/1001; immediate with req_operand[8:7]!=0; target (math mode 01, misc 1100/1101) with req_operand[8]=1.
- Latency: handshake at edge N -> opcode word on wr_en/wr_addr/wr_data during cycle N+1 (registered outputs). Two-word ops: enter ARG, req_ready=0, argument word at addr+1 during cycle N+2, then return to IDLE. Single-word throughput 1/cycle; two-word 1 per 2 cycles.
- Counter increments by 1 per word written; wr_addr = address of the word currently strobed.
- Overflow: if counter + words_needed > DEPTH at accept, write nothing (no partial pair), set overflow, go HALT.
- DONE (misc 1111): word written, done=1 same cycle as its wr_en, go HALT.
- HALT: req_ready=0, wr_en=0 until Start.
- Start has priority over req_valid in the same cycle; request not accepted. Start during ARG abandons the pending argument word (no write).
- Reset asserted during ARG: argument word never written.
- err takes priority only for its own request; it never sets done/overflow.

Test Plan:
- Reset, Start, math ADD mem (class1, op0001, mode00) -> next cycle wr_en=1, wr_addr=0, wr_data=9'h010; req_ready stays 1.
- Math ADD imm 5 (op0001, mode10, operand 9'h005) at addr 1 -> wr_data 9'h018 at addr 1, then 9'h005 at addr 2; req_ready low exactly one cycle.
- Branch equal (class2, op1110, operand 9'h123) -> 9'h1E0 then 9'h123 on consecutive cycles at consecutive addresses.
- Misc DONE (class0, op1111) -> wr_data 9'h00F, done=1; req_ready=0 until Start; after Start, next write at addr 0 with done=0.
- Math op 1010 -> err=1 for one cycle, wr_en never asserted, next legal op written at unchanged address.
- DEPTH=4: three single-word ops (addr 0-2), then STR target (misc 1100) -> no write, overflow=1, HALT; Start clears it.
